// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the issue stage and the multicycle ALU.
interface multicycle_alu_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         alu_control;
    logic               signed_op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic [WIDTH-1:0]   result_lo;
    logic [WIDTH-1:0]   result_hi;
    logic               zero;
    logic               div_by_zero;

    modport master (
        output in_valid, alu_control, signed_op, a, b, shamt,
        input  in_ready, out_valid, result_lo, result_hi, zero, div_by_zero
    );

    modport slave (
        input  in_valid, alu_control, signed_op, a, b, shamt,
        output in_ready, out_valid, result_lo, result_hi, zero, div_by_zero
    );
endinterface

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide with full hi/lo results.
module multicycle_alu #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_alu_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_MULT = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic                 is_div_q, is_div_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_lo_q, result_lo_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic                 zero_q, zero_d;
    logic                 dbz_q, dbz_d;

    logic                 accept_c, b_zero_c, start_mul_c, start_div_c, single_c;
    logic                 sgn_a_c, sgn_b_c, lt_c;
    logic [WIDTH-1:0]     abs_a_c, abs_b_c, alu_res_c;
    logic [WIDTH:0]       mul_sum_c, div_shift_c, div_diff_c;
    logic [2*WIDTH-1:0]   prod_c;

    assign accept_c    = bus.in_valid && (state_q == S_IDLE);
    assign b_zero_c    = (bus.b == '0);
    assign start_mul_c = accept_c && (bus.alu_control == OP_MULT);
    assign start_div_c = accept_c && (bus.alu_control == OP_DIV) && !b_zero_c;
    assign single_c    = accept_c && !start_mul_c && !start_div_c;

    assign sgn_a_c = bus.signed_op && bus.a[WIDTH-1];
    assign sgn_b_c = bus.signed_op && bus.b[WIDTH-1];
    assign abs_a_c = sgn_a_c ? -bus.a : bus.a;
    assign abs_b_c = sgn_b_c ? -bus.b : bus.b;
    assign lt_c    = bus.signed_op ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);

    // One multiply step: add multiplicand into the high half, then shift right.
    assign mul_sum_c   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // One restoring divide step on a WIDTH+1 bit working remainder.
    assign div_shift_c = {rem_q, acc_q[WIDTH-1]};
    assign div_diff_c  = div_shift_c - {1'b0, opb_q};
    assign prod_c      = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;

    always_comb begin
        unique case (bus.alu_control)
            OP_AND:  alu_res_c = bus.a & bus.b;
            OP_OR:   alu_res_c = bus.a | bus.b;
            OP_XOR:  alu_res_c = bus.a ^ bus.b;
            OP_SUB:  alu_res_c = bus.a - bus.b;
            OP_NOR:  alu_res_c = ~(bus.a | bus.b);
            OP_SLT:  alu_res_c = WIDTH'(lt_c);
            OP_SLL:  alu_res_c = bus.a << bus.shamt;
            OP_SRL:  alu_res_c = bus.a >> bus.shamt;
            OP_SRA:  alu_res_c = WIDTH'($signed(bus.a) >>> bus.shamt);
            default: alu_res_c = bus.a + bus.b;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_mul_c)      state_d = S_MUL;
                else if (start_div_c) state_d = S_DIV;
            end
            S_MUL, S_DIV: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d       = acc_q;
        opb_d       = opb_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        is_div_d    = is_div_q;
        out_valid_d = 1'b0;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_mul_c || start_div_c) begin
                    sign_a_d = sgn_a_c;
                    sign_b_d = sgn_b_c;
                    cnt_d    = CNT_W'(WIDTH);
                    is_div_d = start_div_c;
                    rem_d    = '0;
                    opb_d    = start_mul_c ? abs_a_c : abs_b_c;
                    acc_d    = {{WIDTH{1'b0}}, (start_mul_c ? abs_b_c : abs_a_c)};
                end else if (single_c) begin
                    // The only div reaching here has b == 0.
                    dbz_d       = (bus.alu_control == OP_DIV);
                    result_lo_d = dbz_d ? '1 : alu_res_c;
                    result_hi_d = dbz_d ? bus.a : '0;
                    zero_d      = (result_lo_d == '0);
                    out_valid_d = 1'b1;
                end
            end
            S_MUL: begin
                acc_d = {mul_sum_c, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
            end
            S_DIV: begin
                rem_d = div_diff_c[WIDTH] ? div_shift_c[WIDTH-1:0] : div_diff_c[WIDTH-1:0];
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff_c[WIDTH]};
                cnt_d = cnt_q - CNT_W'(1);
            end
            S_FIX: begin
                if (is_div_q) begin
                    result_lo_d = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    result_hi_d = sign_a_q ? -rem_q : rem_q;
                end else begin
                    result_lo_d = prod_c[WIDTH-1:0];
                    result_hi_d = prod_c[2*WIDTH-1:WIDTH];
                end
                zero_d      = (result_lo_d == '0);
                dbz_d       = 1'b0;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            opb_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            is_div_q    <= 1'b0;
            out_valid_q <= 1'b0;
            result_lo_q <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            is_div_q    <= is_div_d;
            out_valid_q <= out_valid_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.result_lo   = result_lo_q;
    assign bus.result_hi   = result_hi_q;
    assign bus.zero        = zero_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu (WIDTH=32).
module tb_multicycle_alu;
    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, SLT = 4'b0111, MULT = 4'b0101;
    localparam logic [3:0] SLL = 4'b1000, SRL = 4'b1001, SRA = 4'b1010, DIV = 4'b1011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    multicycle_alu_if #(.WIDTH(32), .SHAMT_W(5)) bus ();
    multicycle_alu #(.WIDTH(32), .SHAMT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [3:0] op, input logic sgn, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] sh);
        bus.in_valid    = 1'b1;
        bus.alu_control = op;
        bus.signed_op   = sgn;
        bus.a           = av;
        bus.b           = bv;
        bus.shamt       = sh;
    endtask

    // Issue one op and count edges until out_valid; optionally spam ignored requests while busy.
    task automatic run_op(input logic [3:0] op, input logic sgn, input logic [31:0] av,
                          input logic [31:0] bv, input logic noise, output int edges, output int busy);
        edges = -1;
        busy  = 0;
        @(negedge clk);
        drive(op, sgn, av, bv, 5'd0);
        for (int k = 0; k < 100; k++) begin
            if (k > 0) begin
                @(negedge clk);
                bus.in_valid = noise;
                if (noise) drive(ADD, 1'b0, $urandom, $urandom, 5'd3);
            end
            @(posedge clk);
            #1;
            if (!bus.in_ready) busy++;
            if (bus.out_valid) begin
                edges = k;
                break;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b0;
        drive(ADD, 1'b0, 32'd0, 32'd0, 5'd0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.result_lo, bus.result_hi, bus.zero, bus.div_by_zero} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs: got lo=%h hi=%h ov=%b z=%b dbz=%b exp all 0",
                     bus.result_lo, bus.result_hi, bus.out_valid, bus.zero, bus.div_by_zero);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b ov=%b exp rdy=1 ov=0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ops [4] = '{ADD, SUB, SLT, SLT};
        logic        sg  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] av  [4] = '{32'd7, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bv  [4] = '{32'd5, 32'd3, 32'd1, 32'd1};
        logic [31:0] exp [4] = '{32'd12, 32'd0, 32'd1, 32'd0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(ops[i], sg[i], av[i], bv[i], 5'd0);
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.result_lo !== exp[i] ||
                bus.result_hi !== 32'd0 || bus.zero !== (exp[i] == 32'd0)) begin
                errors++;
                $display("FAIL b2b_%0d: got ov=%b rdy=%b lo=%h hi=%h z=%b exp ov=1 rdy=1 lo=%h hi=0",
                         i, bus.out_valid, bus.in_ready, bus.result_lo, bus.result_hi, bus.zero, exp[i]);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result_lo !== 32'd0 || bus.zero !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: got ov=%b lo=%h z=%b exp ov=0 lo=0 z=1",
                     bus.out_valid, bus.result_lo, bus.zero);
        end
    endtask

    task automatic test_shifts;
        logic [3:0]  ops [3] = '{SRA, SRL, SLL};
        logic [31:0] av  [3] = '{32'h80000000, 32'h80000000, 32'h00000001};
        logic [4:0]  sh  [3] = '{5'd4, 5'd4, 5'd31};
        logic [31:0] exp [3] = '{32'hF8000000, 32'h08000000, 32'h80000000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(ops[i], 1'b0, av[i], 32'd0, sh[i]);
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result_lo !== exp[i] || bus.result_hi !== 32'd0) begin
                errors++;
                $display("FAIL shift_%0d: got ov=%b lo=%h hi=%h exp ov=1 lo=%h hi=0",
                         i, bus.out_valid, bus.result_lo, bus.result_hi, exp[i]);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_mult;
        int edges, busy;
        run_op(MULT, 1'b1, 32'hFFFFFFFD, 32'd5, 1'b1, edges, busy);
        checks++;
        if (edges != 33 || busy != 33 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mult_timing: got edges=%0d busy=%0d exp edges=33 busy=33", edges, busy);
        end
        checks++;
        if (bus.result_hi !== 32'hFFFFFFFF || bus.result_lo !== 32'hFFFFFFF1 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL mult_signed: got hi=%h lo=%h exp hi=ffffffff lo=fffffff1",
                     bus.result_hi, bus.result_lo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mult_noise_ignored: got ov=%b rdy=%b exp ov=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        run_op(MULT, 1'b0, 32'hFFFFFFFF, 32'd2, 1'b0, edges, busy);
        checks++;
        if (edges != 33 || bus.result_hi !== 32'd1 || bus.result_lo !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL mult_unsigned: got edges=%0d hi=%h lo=%h exp edges=33 hi=1 lo=fffffffe",
                     edges, bus.result_hi, bus.result_lo);
        end
    endtask

    task automatic test_div;
        int edges, busy;
        run_op(DIV, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, edges, busy);
        checks++;
        if (edges != 33 || busy != 33 || bus.result_lo !== 32'hFFFFFFFD || bus.result_hi !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL div_signed: got edges=%0d busy=%0d lo=%h hi=%h exp 33 33 lo=fffffffd hi=ffffffff",
                     edges, busy, bus.result_lo, bus.result_hi);
        end
        run_op(DIV, 1'b0, 32'd100, 32'd7, 1'b0, edges, busy);
        checks++;
        if (bus.result_lo !== 32'd14 || bus.result_hi !== 32'd2 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL div_unsigned: got lo=%h hi=%h dbz=%b exp lo=e hi=2 dbz=0",
                     bus.result_lo, bus.result_hi, bus.div_by_zero);
        end
        run_op(DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, edges, busy);
        checks++;
        if (bus.result_lo !== 32'h80000000 || bus.result_hi !== 32'd0) begin
            errors++;
            $display("FAIL div_min_neg1: got lo=%h hi=%h exp lo=80000000 hi=0", bus.result_lo, bus.result_hi);
        end
    endtask

    task automatic test_div_by_zero;
        int edges, busy;
        run_op(DIV, 1'b0, 32'h1234, 32'd0, 1'b0, edges, busy);
        checks++;
        if (edges != 0 || busy != 0 || bus.result_lo !== 32'hFFFFFFFF || bus.result_hi !== 32'h1234 ||
            bus.div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL div_zero: got edges=%0d busy=%0d lo=%h hi=%h dbz=%b exp 0 0 lo=ffffffff hi=1234 dbz=1",
                     edges, busy, bus.result_lo, bus.result_hi, bus.div_by_zero);
        end
        run_op(ADD, 1'b0, 32'd1, 32'd1, 1'b0, edges, busy);
        checks++;
        if (bus.div_by_zero !== 1'b0 || bus.result_lo !== 32'd2 || bus.result_hi !== 32'd0) begin
            errors++;
            $display("FAIL div_zero_clear: got dbz=%b lo=%h hi=%h exp dbz=0 lo=2 hi=0",
                     bus.div_by_zero, bus.result_lo, bus.result_hi);
        end
    endtask

    task automatic test_reset_mid_op;
        int  edges, busy;
        logic seen = 1'b0;
        @(negedge clk);
        drive(DIV, 1'b0, 32'd100, 32'd7, 5'd0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.result_lo, bus.result_hi, bus.zero, bus.div_by_zero} !== 67'd0 ||
            bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got lo=%h hi=%h ov=%b z=%b dbz=%b rdy=%b exp all 0 rdy=1",
                     bus.result_lo, bus.result_hi, bus.out_valid, bus.zero, bus.div_by_zero, bus.in_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_discard: got pulse=%b rdy=%b exp pulse=0 rdy=1", seen, bus.in_ready);
        end
        run_op(MULT, 1'b0, 32'd6, 32'd7, 1'b0, edges, busy);
        checks++;
        if (edges != 33 || bus.result_lo !== 32'd42 || bus.result_hi !== 32'd0) begin
            errors++;
            $display("FAIL reset_then_mult: got edges=%0d lo=%h hi=%h exp edges=33 lo=2a hi=0",
                     edges, bus.result_lo, bus.result_hi);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_shifts();
        test_mult();
        test_div();
        test_div_by_zero();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
